// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port fixed-priority arbiter and sequencer for the single-port data memory.
// Port 0 (load/store stage) has priority. An aging counter forces a port-1 grant after
// MAX_WAIT consecutive denied cycles. The response returns one cycle after the grant.
// Optional feature: define DMEM_ARB_PERF_EN to add saturating grant/conflict counters.
module dmem_arbiter #(
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned MAX_WAIT = 4
`ifdef DMEM_ARB_PERF_EN
    ,
    parameter int unsigned CNT_W    = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [31:0] result,
    output logic [31:0] rdb,
    input  logic [31:0] read_data
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] p0_gnt_cnt,
    output logic [CNT_W-1:0] p1_gnt_cnt,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    localparam int unsigned AW     = 32;
    localparam int unsigned WAIT_W = 4;

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              rsp_pend_q, rsp_pend_d;
    logic              rsp_port_q, rsp_port_d;
    logic              rsp_rd_q,   rsp_rd_d;
    logic              rsp_err_q,  rsp_err_d;

    logic              p0_win, p1_win, any_win;
    logic              sel_we, in_range;
    logic [AW-1:0]     sel_addr;
    logic [31:0]       sel_wdata;

    // Winner selection, memory drive and next state for the response/aging registers.
    // The winner is suppressed while reset is asserted so grants and strobes stay low.
    always_comb begin
        p0_win     = 1'b0;
        p1_win     = 1'b0;
        result     = '0;
        rdb        = '0;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        wait_cnt_d = '0;
        if (reset) begin
            p1_win = p1_req && (!p0_req || (wait_cnt_q == WAIT_W'(MAX_WAIT)));
            p0_win = p0_req && !p1_win;
        end
        any_win   = p0_win || p1_win;
        sel_we    = p1_win ? p1_we    : p0_we;
        sel_addr  = p1_win ? p1_addr  : p0_addr;
        sel_wdata = p1_win ? p1_wdata : p0_wdata;
        in_range  = (sel_addr < AW'(DEPTH));
        if (any_win && in_range) begin
            result = sel_addr;
            rdb    = sel_wdata;
            mem_wr = sel_we;
            mem_rd = !sel_we;
        end
        if (p1_req && !p1_win) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q
                                                            : wait_cnt_q + WAIT_W'(1);
        end
        rsp_pend_d = any_win;
        rsp_port_d = p1_win;
        rsp_rd_d   = any_win && !sel_we;
        rsp_err_d  = any_win && !in_range;
    end

    // Aging counter and one-deep response register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            rsp_pend_q <= 1'b0;
            rsp_port_q <= 1'b0;
            rsp_rd_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_port_q <= rsp_port_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Grants and responses; read data passes through only for in-range reads.
    always_comb begin
        p0_gnt    = p0_win;
        p1_gnt    = p1_win;
        p0_rvalid = rsp_pend_q && !rsp_port_q;
        p1_rvalid = rsp_pend_q &&  rsp_port_q;
        p0_err    = p0_rvalid && rsp_err_q;
        p1_err    = p1_rvalid && rsp_err_q;
        p0_rdata  = (p0_rvalid && rsp_rd_q && !rsp_err_q) ? read_data : '0;
        p1_rdata  = (p1_rvalid && rsp_rd_q && !rsp_err_q) ? read_data : '0;
    end

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] p0_gnt_cnt_q, p0_gnt_cnt_d;
    logic [CNT_W-1:0] p1_gnt_cnt_q, p1_gnt_cnt_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    // Saturating performance counter increments.
    always_comb begin
        p0_gnt_cnt_d   = p0_gnt_cnt_q;
        p1_gnt_cnt_d   = p1_gnt_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (p0_win && (p0_gnt_cnt_q != '1)) begin
            p0_gnt_cnt_d = p0_gnt_cnt_q + CNT_W'(1);
        end
        if (p1_win && (p1_gnt_cnt_q != '1)) begin
            p1_gnt_cnt_d = p1_gnt_cnt_q + CNT_W'(1);
        end
        if (p0_req && p1_req && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p0_gnt_cnt_q   <= '0;
            p1_gnt_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            p0_gnt_cnt_q   <= p0_gnt_cnt_d;
            p1_gnt_cnt_q   <= p1_gnt_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign p0_gnt_cnt   = p0_gnt_cnt_q;
    assign p1_gnt_cnt   = p1_gnt_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus for dmem_arbiter with a queue-based response scoreboard.
// A behavioural single-port memory with registered read data sits behind the arbiter.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_wr, mem_rd;
    logic [31:0] result, rdb, read_data;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] p0_gnt_cnt, p1_gnt_cnt, conflict_cnt;
`endif

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .result    (result),
        .rdb       (rdb),
        .read_data (read_data)
`ifdef DMEM_ARB_PERF_EN
        ,
        .p0_gnt_cnt   (p0_gnt_cnt),
        .p1_gnt_cnt   (p1_gnt_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: write on the edge, read data registered one cycle after mem_rd.
    logic [31:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        read_data = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_wr) mem[result[6:0]] <= rdb;
        if (mem_rd) read_data <= mem[result[6:0]];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: each rvalid must match the oldest expectation, one cycle after its grant.
    always @(negedge clk) begin
        exp_t e;
        if (p0_rvalid || p1_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: p0_rvalid=%b p1_rvalid=%b (cycle %0d)",
                         p0_rvalid, p1_rvalid, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_both_valid", 32'(p0_rvalid && p1_rvalid), 32'h0);
                check("rsp_port", 32'(p1_rvalid), 32'(e.port));
                check("rsp_cycle", 32'(cyc), 32'(e.cyc + 1));
                check("rsp_rdata", p1_rvalid ? p1_rdata : p0_rdata, e.data);
                check("rsp_err", 32'(p1_rvalid ? p1_err : p0_err), 32'(e.err));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc + 1 == cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_rvalid: got none expected port %0d response (cycle %0d)",
                     e.port, cyc);
        end
    end

    // One cycle of stimulus: drive after the edge, check grant/strobes at the negedge.
    task automatic step(input string tag,
                        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic eg0, input logic eg1, input logic [31:0] erd, input logic eerr,
                        input logic emwr, input logic emrd);
        exp_t e;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        @(negedge clk);
        check({tag, " p0_gnt"}, 32'(p0_gnt), 32'(eg0));
        check({tag, " p1_gnt"}, 32'(p1_gnt), 32'(eg1));
        check({tag, " mem_wr"}, 32'(mem_wr), 32'(emwr));
        check({tag, " mem_rd"}, 32'(mem_rd), 32'(emrd));
        if (eg0 || eg1) begin
            e = '{port: (eg1 ? 1 : 0), data: erd, err: eerr, cyc: cyc};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " p0_gnt"},    32'(p0_gnt),    32'h0);
        check({tag, " p1_gnt"},    32'(p1_gnt),    32'h0);
        check({tag, " p0_rvalid"}, 32'(p0_rvalid), 32'h0);
        check({tag, " p1_rvalid"}, 32'(p1_rvalid), 32'h0);
        check({tag, " p0_err"},    32'(p0_err),    32'h0);
        check({tag, " p1_err"},    32'(p1_err),    32'h0);
        check({tag, " p0_rdata"},  p0_rdata,       32'h0);
        check({tag, " p1_rdata"},  p1_rdata,       32'h0);
        check({tag, " mem_wr"},    32'(mem_wr),    32'h0);
        check({tag, " mem_rd"},    32'(mem_rd),    32'h0);
    endtask

    initial begin
        // Reset with both ports requesting: nothing may be granted.
        reset = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd3; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd4; p1_wdata = 32'h0;
        @(negedge clk);
        check_all_zero("reset");
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Port 0 write then read-back of the same word.
        step("p0_wr5", 1, 1, 32'd5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 32'h0, 0, 1, 0);
        step("p0_rd5", 1, 0, 32'd5, 32'h0,        0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 1);

        // Port 1 boundary: last valid word, then first out-of-range word.
        step("p1_wr127", 0, 0, 0, 0, 1, 1, 32'd127, 32'hCAFE0127, 0, 1, 32'h0, 0, 1, 0);
        step("p1_rd127", 0, 0, 0, 0, 1, 0, 32'd127, 32'h0,        0, 1, 32'hCAFE0127, 0, 0, 1);
        step("p1_rd128", 0, 0, 0, 0, 1, 0, 32'd128, 32'h0,        0, 1, 32'h0, 1, 0, 0);
        step("p1_wr128", 0, 0, 0, 0, 1, 1, 32'd128, 32'h12345678, 0, 1, 32'h0, 1, 0, 0);
        step("p0_rdbig", 1, 0, 32'hFFFF_0005, 0, 0, 0, 0, 0,      1, 0, 32'h0, 1, 0, 0);
        step("p0_rd127", 1, 0, 32'd127, 0, 0, 0, 0, 0,            1, 0, 32'hCAFE0127, 0, 0, 1);

        // Cross-port read-after-write on back-to-back cycles.
        step("p0_wr10", 1, 1, 32'd10, 32'h11, 0, 0, 0, 0, 1, 0, 32'h0, 0, 1, 0);
        step("p1_rd10", 0, 0, 0, 0, 1, 0, 32'd10, 32'h0, 0, 1, 32'h11, 0, 0, 1);

        // Same address from both ports: port 0 wins, port 1 holds and is served next.
        step("both_rd5", 1, 0, 32'd5, 0, 1, 0, 32'd5, 0, 1, 0, 32'hDEADBEEF, 0, 0, 1);
        step("p1_rd5",   0, 0, 0, 0,     1, 0, 32'd5, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1);
        idle("idle0");

        // Reset pulsed after a port-0 grant: its response must be dropped.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd5; p0_wdata = 32'h0;
        @(negedge clk);
        check("rst_mid p0_gnt", 32'(p0_gnt), 32'h1);
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid_low");
        @(posedge clk);
        #1;
        check_all_zero("rst_mid_edge");
        @(negedge clk);
        reset  = 1'b1;
        p0_req = 1'b0;
        @(posedge clk);
        #1;
        idle("post_rst0");
        idle("post_rst1");
        idle("post_rst2");

        // Continuous dual requests: four port-0 grants, then a forced port-1 grant, repeating.
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                step("aging", 1, 0, 32'd5, 0, 1, 0, 32'd10, 0, 0, 1, 32'h11, 0, 0, 1);
            else
                step("aging", 1, 0, 32'd5, 0, 1, 0, 32'd10, 0, 1, 0, 32'hDEADBEEF, 0, 0, 1);
        end
        p0_req = 1'b0; p1_req = 1'b0;
`ifdef DMEM_ARB_PERF_EN
        check("perf p0_gnt_cnt",   32'(p0_gnt_cnt),   32'd8);
        check("perf p1_gnt_cnt",   32'(p1_gnt_cnt),   32'd2);
        check("perf conflict_cnt", 32'(conflict_cnt), 32'd10);
`endif
        idle("drain0");
        idle("drain1");
        idle("drain2");
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 128-word data memory.
- Port 0 serves the pipeline load/store stage; port 1 serves the DMA/debug loader.
- Drives the memory's mem_wr/mem_rd/result/rdb inputs, captures read_data, and returns a one-cycle-later response to the winning port.
- Port 0 has fixed priority, with an aging counter that guarantees port 1 service.

Parameters:
DEPTH, 128, number of memory words; a word address >= DEPTH is out of range
MAX_WAIT, 4, consecutive denied port-1 cycles before port 1 is forced a grant (1..15)
CNT_W, 16, width of performance counters (only with DMEM_ARB_PERF_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
p0_req  in  1  port 0 access request
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  32  port 0 word address
p0_wdata  in  32  port 0 write data
p0_gnt  out  1  port 0 request accepted this cycle
p0_rvalid  out  1  port 0 response valid
p0_rdata  out  32  port 0 read data
p0_err  out  1  port 0 response is an out-of-range error
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err  (same as port 0)
mem_wr  out  1  memory write strobe
mem_rd  out  1  memory read strobe
result  out  32  memory word address
rdb  out  32  memory write data
read_data  in  32  memory registered read data, valid the cycle after mem_rd

Behaviour:
- Reset (reset=0, asynchronous): wait_cnt=0, rsp_pend=0, rsp_port=0, rsp_rd=0, rsp_err=0.
  - All gnt, rvalid and err outputs are 0; rdata is 0; mem_wr=mem_rd=0.
- Winner selection (combinational, same cycle):
  - p1 wins if p1_req && (!p0_req || wait_cnt==MAX_WAIT).
  - Otherwise p0 wins if p0_req.
  - Otherwise there is no winner.
- Grant: pX_gnt=1 for the winner only. A requester holds req/we/addr/wdata stable until it sees gnt. There is no back-pressure on responses.
- Memory drive (combinational from the winner):
  - Address is in range (addr < DEPTH): result=addr, rdb=wdata, mem_wr=we, mem_rd=!we.
  - Address is out of range: mem_wr=mem_rd=0; the access is still granted.
  - mem_wr and mem_rd are never both 1.
  - With no winner: result=0, rdb=0, strobes 0.
- Response register, updated on the clk edge:
  - rsp_pend <= winner exists.
  - rsp_port, rsp_rd, rsp_err are captured from the winner.
  - Exactly one cycle after a grant, pX_rvalid=1 for that port only.
  - Read, in range: pX_rdata=read_data.
  - Write, or out-of-range access: pX_rdata=0.
  - pX_err=rsp_err, qualified by rvalid.
- Throughput: one grant per cycle. Back-to-back grants to alternating ports are allowed. A write at cycle N followed by a read of the same address at cycle N+1 returns the new data.
- Aging:
  - wait_cnt increments, saturating at MAX_WAIT, on each cycle with p1_req=1 and p1 not granted.
  - wait_cnt clears to 0 when p1 is granted or p1_req=0.
- Simultaneous requests, same address: only the winner is serviced; the loser waits. There is no merging.
- Reset mid-operation: a pending response is dropped. No rvalid is produced after reset deasserts until a new grant.

Optional Feature:
- Macro DMEM_ARB_PERF_EN. When defined, adds three outputs:
  - p0_gnt_cnt [CNT_W]: number of port 0 grants.
  - p1_gnt_cnt [CNT_W]: number of port 1 grants.
  - conflict_cnt [CNT_W]: number of cycles with p0_req&&p1_req.
- All counters clear on reset, saturate at all-ones, and update on the clock edge.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Port 0 writes 0xDEADBEEF to addr 5. Next cycle, port 0 reads addr 5 -> p0_gnt on both cycles; the read's p0_rvalid one cycle later carries p0_rdata=0xDEADBEEF, p0_err=0.
- Both ports request reads every cycle with MAX_WAIT=4 -> p0 granted 4 cycles, then p1 granted on the 5th; pattern repeats; wait_cnt never exceeds 4.
- Port 1 alone reads addr 127, then addr 128 -> first response has err=0 with data; second has p1_err=1, p1_rdata=0, and mem_rd=0 in the grant cycle.
- Port 0 writes addr 10=0x11 at cycle N, port 1 reads addr 10 at cycle N+1 -> p1_rdata=0x11 at N+2, with p1_rvalid high and p0_rvalid low at N+2.
- Port 0 read granted, then reset pulsed low for one cycle before the response edge -> no p0_rvalid ever appears; all outputs are 0 during reset.
- With DMEM_ARB_PERF_EN: 10 cycles of dual requests, MAX_WAIT=4 -> p0_gnt_cnt=8, p1_gnt_cnt=2, conflict_cnt=10.
